div_32: RTL and testbench

DIV_32 -- requirements
Module: div_32

---
 rtl/div_32.sv | 135 +++++++++++++
 tb/tb_div_32.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/div_32.sv
// Signed 32-bit restoring divider (truncating); optional DIV_ZERO_DETECT_EN gives a 1-cycle divide-by-zero path.
// Latency: done pulses the cycle after edge k+33 for a start at edge k (k+1 on the zero-detect path).
// Backpressure: start is only sampled in IDLE; a start while busy is dropped, and results hold until the next completion.
module div_32 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);
   localparam int CNT_W = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] dvs_q;
   logic             neg_quo_q;
   logic             neg_rem_q;
   logic             dz_q;

   logic [WIDTH-1:0] dvd_mag;
   logic [WIDTH-1:0] dvs_mag;
   logic [WIDTH:0]   rem_shift;
   logic             step_ge;
   logic [WIDTH-1:0] rem_sub;
   logic             zero_start;

   // Unsigned magnitudes: -2^31 maps onto 0x8000_0000 without overflow.
   assign dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
   assign dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;

   // The shifted partial remainder can need one extra bit; after a kept
   // subtraction the result always fits back into WIDTH bits.
   assign rem_shift = {rem_q, quo_q[WIDTH-1]};
   assign step_ge   = rem_shift >= {1'b0, dvs_q};
   assign rem_sub   = rem_shift[WIDTH-1:0] - dvs_q;

   assign busy = (state_q != IDLE);

`ifdef DIV_ZERO_DETECT_EN
   assign zero_start = (divisor == '0);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         dz_q     <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         if (state_q == IDLE && start)
            dz_q <= zero_start;
         if (state_q == FIX)
            div_zero <= dz_q;
      end
   end
`else
   assign zero_start = 1'b0;
   assign dz_q       = 1'b0;
   assign div_zero   = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start) state_d = zero_start ? FIX : CALC;
         CALC: if (cnt_q == CNT_W'(1)) state_d = FIX;
         FIX:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         done      <= 1'b0;
      end else begin
         done <= (state_q == FIX);
         case (state_q)
            IDLE: begin
               if (start) begin
                  quo_q     <= dvd_mag;
                  dvs_q     <= dvs_mag;
                  rem_q     <= '0;
                  cnt_q     <= CNT_W'(WIDTH);
                  neg_quo_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                  neg_rem_q <= dividend[WIDTH-1];
               end
            end
            CALC: begin
               rem_q <= step_ge ? rem_sub : rem_shift[WIDTH-1:0];
               quo_q <= {quo_q[WIDTH-2:0], step_ge};
               cnt_q <= cnt_q - CNT_W'(1);
            end
            FIX: begin
               // On the zero-detect path quo_q still holds |dividend|.
               if (dz_q) begin
                  quotient  <= '1;
                  remainder <= neg_rem_q ? -quo_q : quo_q;
               end else begin
                  quotient  <= neg_quo_q ? -quo_q : quo_q;
                  remainder <= neg_rem_q ? -rem_q : rem_q;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_32.sv
// Scoreboard bench for div_32: expected results are queued at start and checked at done.
module tb_div_32;
   logic        clk;
   logic        n_rst;
   logic        start;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        busy;
   logic        done;
   logic        div_zero;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   cyc    = 0;
   int   k_cyc  = 0;

   div_32 dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .quotient  (quotient),
      .remainder (remainder),
      .busy      (busy),
      .done      (done),
      .div_zero  (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
      exp_t m;
      int   sa;
      int   sd;
      sa = a;
      sd = b;
      if (b == 32'h0) begin
`ifdef DIV_ZERO_DETECT_EN
         m.q   = 32'hFFFF_FFFF;
         m.dz  = 1'b1;
         m.lat = 1;
`else
         m.q   = a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF;
         m.dz  = 1'b0;
         m.lat = 33;
`endif
         m.r = a;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         m.q   = 32'h8000_0000;
         m.r   = 32'h0;
         m.dz  = 1'b0;
         m.lat = 33;
      end else begin
         m.q   = 32'(sa / sd);
         m.r   = 32'(sa % sd);
         m.dz  = 1'b0;
         m.lat = 33;
      end
      return m;
   endfunction

   // Called while clk is low; the start is sampled by the next rising edge.
   task automatic start_op(input logic [31:0] a, input logic [31:0] b);
      sb.push_back(model(a, b));
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      #1;
      k_cyc    = cyc;
      start    = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
      check("done_pulse_width", 32'(done), 32'h0);
   endtask

   task automatic wait_done(input string tag);
      bit   got;
      exp_t e;
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            break;
         end
      end
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 32'h1, 32'h0);
      end else begin
         e = sb.pop_front();
         if (!got) begin
            check({tag, "_timeout"}, 32'h0, 32'h1);
         end else begin
            check({tag, "_quotient"}, quotient, e.q);
            check({tag, "_remainder"}, remainder, e.r);
            check({tag, "_div_zero"}, 32'(div_zero), 32'(e.dz));
            check({tag, "_latency"}, 32'(cyc - k_cyc), 32'(e.lat));
            check({tag, "_busy_clear"}, 32'(busy), 32'h0);
         end
      end
   endtask

   initial begin
      bit          seen_done;
      logic [31:0] a;
      logic [31:0] b;

      n_rst    = 1'b0;
      start    = 1'b0;
      dividend = 32'h0;
      divisor  = 32'h0;
      repeat (3) @(negedge clk);
      check("rst_quotient", quotient, 32'h0);
      check("rst_remainder", remainder, 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_div_zero", 32'(div_zero), 32'h0);
      n_rst = 1'b1;

      // First start right after reset release, then a back-to-back chain
      // where each start is driven during the done cycle of the previous op.
      start_op(32'h0000_00A0, 32'h0000_0008);
      check("busy_after_start", 32'(busy), 32'h1);
      wait_done("pos_div");
      start_op(32'hFFFF_FFD5, 32'h0000_0003);
      wait_done("neg_dividend");
      start_op(32'h0000_00A0, 32'hFFFF_FFF8);
      wait_done("neg_divisor");
      start_op(32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("min_by_m1");
      start_op(32'h0000_0007, 32'h0000_0000);
      wait_done("div_by_zero_pos");
      start_op(32'hFFFF_FFF9, 32'h0000_0000);
      wait_done("div_by_zero_neg");
      start_op(32'h8000_0000, 32'h8000_0000);
      wait_done("min_by_min");
      start_op(32'h0000_0005, 32'h0000_0007);
      wait_done("small_by_large");

      // A start while busy must be ignored.
      @(negedge clk);
      start_op(32'd100, 32'd7);
      repeat (9) @(negedge clk);
      start    = 1'b1;
      dividend = 32'd50;
      divisor  = 32'd5;
      @(posedge clk);
      #1;
      start    = 1'b0;
      check("busy_ignored_start", 32'(busy), 32'h1);
      wait_done("ignore_start");

      // Reset in mid-calculation aborts the operation silently.
      @(negedge clk);
      start_op(32'd1000, 32'd3);
      repeat (14) @(negedge clk);
      n_rst = 1'b0;
      #1;
      void'(sb.pop_back());
      check("abort_quotient", quotient, 32'h0);
      check("abort_remainder", remainder, 32'h0);
      check("abort_busy", 32'(busy), 32'h0);
      check("abort_done", 32'(done), 32'h0);
      check("abort_div_zero", 32'(div_zero), 32'h0);
      seen_done = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done) seen_done = 1'b1;
      end
      check("abort_no_done", 32'(seen_done), 32'h0);
      n_rst = 1'b1;
      start_op(32'd20, 32'd4);
      wait_done("after_abort");

      for (int i = 0; i < 12; i++) begin
         a = $urandom;
         b = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
         if (i % 4 == 1) b = -b;
         start_op(a, b);
         wait_done("random");
      end

      check("sb_drained", 32'(sb.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
